// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared defaults, FSM encoding and priority helper for the interrupt controller
//
// Contents:
//   N_IRQ_DEFAULT       default number of request lines
//   VEC_BASE_DEFAULT    default vector address of line 0
//   VEC_STRIDE_DEFAULT  default vector spacing per line
//   state_t             request FSM encoding (IDLE / REQ)
//   hsb_t               highest-set-bit result (valid flag + index)
//   highest_set()       highest set bit of a vector, valid=0 when empty
package irq_pkg;

  localparam int          N_IRQ_DEFAULT      = 3;
  localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'h0000_0010;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } hsb_t;

  // Callers zero-extend their vector to 32 bits; an empty vector returns
  // valid=0, which the eligibility check treats as "below every line".
  function automatic hsb_t highest_set(input logic [31:0] v);
    hsb_t r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-line input synchroniser with rising-edge detector
//
// Ports:
//   clk      system clock
//   rst      synchronous active-low reset
//   irq_raw  raw asynchronous request line
//   rise     one-cycle pulse on a synchronised 0->1 transition
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  output logic rise
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_COUNT = CW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CW-1:0]          arm_cnt;
  logic                   armed;

  // After reset the chain refills with whatever the line currently holds.
  // Edge reporting stays off until every stage and the edge register carry
  // real samples, so a line that was already high through reset is not
  // mistaken for a fresh press.
  assign armed = (arm_cnt == ARM_COUNT);
  assign rise  = armed && sync[SYNC_STAGES-1] && !prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync    <= '0;
      prev    <= 1'b0;
      arm_cnt <= '0;
    end else begin
      sync[0] <= irq_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync[k] <= sync[k-1];
      end
      prev <= sync[SYNC_STAGES-1];
      if (!armed) begin
        arm_cnt <= arm_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised nesting interrupt controller with req/ack handshake
//
// Ports:
//   clk      system clock, all state updates on rising edge
//   rst      synchronous active-low reset
//   irq_in   raw asynchronous requests, active-high
//   ie_set   pulse: EI-type instruction retired
//   ie_clr   pulse: DI-type instruction retired
//   irq_ack  pulse: pipeline has taken the interrupt
//   eret     pulse: ERET retired
//   irq_req  interrupt request to pipeline
//   irq_id   line being requested
//   irq_vec  handler address = VEC_BASE + irq_id*VEC_STRIDE
//   ie       global interrupt enable
//   pending  latched pending bits
//   irw      in-service bits (LEDs)
module irq_controller
  import irq_pkg::*;
#(
  parameter int               N_IRQ       = N_IRQ_DEFAULT,
  parameter int               SYNC_STAGES = 2,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] VEC_BASE    = WIDTH'(VEC_BASE_DEFAULT),
  parameter logic [WIDTH-1:0] VEC_STRIDE  = WIDTH'(VEC_STRIDE_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             ie_set,
  input  logic             ie_clr,
  input  logic             irq_ack,
  input  logic             eret,
  output logic             irq_req,
  output logic [1:0]       irq_id,
  output logic [WIDTH-1:0] irq_vec,
  output logic             ie,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] irw
);

  logic [N_IRQ-1:0] rise;
  state_t           state;
  state_t           state_next;
  hsb_t             top_pend;
  hsb_t             top_svc;
  logic             eligible;
  logic             ack_fire;
  logic             eret_hold;
  logic             eret_now;
  logic [N_IRQ-1:0] ack_mask;
  logic [N_IRQ-1:0] eret_mask;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_raw(irq_in[g]),
      .rise   (rise[g])
    );
  end

  always_comb begin
    top_pend = highest_set(32'(pending));
    top_svc  = highest_set(32'(irw));
  end

  // Strictly higher than the deepest in-service level; an empty irw acts as -1.
  assign eligible = ie && top_pend.valid && (!top_svc.valid || (top_pend.idx > top_svc.idx));

  // irq_ack outside REQ is not an interrupt being taken and is ignored.
  assign ack_fire = (state == REQ) && irq_ack;

  // An eret colliding with an ack is parked in eret_hold and replayed on the
  // following cycle, so the ack's irw/ie update is never lost.
  assign eret_now = !ack_fire && (eret_hold || eret);

  always_comb begin
    ack_mask  = '0;
    eret_mask = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      ack_mask[i]  = ack_fire && (irq_id == 2'(i));
      eret_mask[i] = eret_now && top_svc.valid && (top_svc.idx == 5'(i));
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (eligible) begin
          state_next = REQ;
        end
      end
      REQ: begin
        // Ack takes precedence; ie_clr alone withdraws the request.
        if (irq_ack || ie_clr) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      irq_id    <= '0;
      pending   <= '0;
      irw       <= '0;
      ie        <= 1'b0;
      eret_hold <= 1'b0;
    end else begin
      state <= state_next;

      // irq_id is captured only on entry to REQ, so it stays frozen while
      // the pipeline is deciding, even if a higher line becomes pending.
      if ((state == IDLE) && (state_next == REQ)) begin
        irq_id <= top_pend.idx[1:0];
      end

      // A new edge on the line being acked wins over the ack's clear.
      pending <= (pending & ~ack_mask) | rise;

      irw <= (irw & ~eret_mask) | ack_mask;

      // Disabling beats enabling: ack and ie_clr override eret and ie_set.
      if (ack_fire || ie_clr) begin
        ie <= 1'b0;
      end else if (eret_now || ie_set) begin
        ie <= 1'b1;
      end

      if (ack_fire) begin
        eret_hold <= eret_hold | eret;
      end else begin
        // A held eret is consumed now; a fresh eret arriving alongside it
        // takes its place for the next cycle.
        eret_hold <= eret_hold & eret;
      end
    end
  end

  assign irq_req = (state == REQ);
  assign irq_vec = VEC_BASE + (WIDTH'(irq_id) * VEC_STRIDE);

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed scoreboard bench for irq_controller
module tb_irq_controller;

  logic        clk;
  logic        rst;
  logic [2:0]  irq_in;
  logic        ie_set;
  logic        ie_clr;
  logic        irq_ack;
  logic        eret;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [31:0] irq_vec;
  logic        ie;
  logic [2:0]  pending;
  logic [2:0]  irw;

  int n_checks = 0;
  int n_fails  = 0;

  string       tag_q[$];
  logic [63:0] exp_q[$];

  irq_controller dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .ie_set (ie_set),
    .ie_clr (ie_clr),
    .irq_ack(irq_ack),
    .eret   (eret),
    .irq_req(irq_req),
    .irq_id (irq_id),
    .irq_vec(irq_vec),
    .ie     (ie),
    .pending(pending),
    .irw    (irw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fails++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; ie_set = 0; ie_clr = 0; irq_ack = 0; eret = 0;
    cyc(2);
    push("rst_pending", 0); push("rst_irw", 0); push("rst_ie", 0);
    push("rst_req", 0); push("rst_id", 0);
    pop_check(64'(pending)); pop_check(64'(irw)); pop_check(64'(ie));
    pop_check(64'(irq_req)); pop_check(64'(irq_id));
    rst = 1'b1;
    cyc(4);

    // 1: single request on line 0
    push("t1_ie", 1);
    ie_set = 1; cyc(1); ie_set = 0;
    pop_check(64'(ie));
    push("t1_pend_early", 0); push("t1_pend", 3'b001); push("t1_req_pre", 0);
    push("t1_req", 1); push("t1_id", 0); push("t1_vec", 32'h100);
    irq_in = 3'b001;
    cyc(2); pop_check(64'(pending));
    cyc(1); pop_check(64'(pending)); pop_check(64'(irq_req));
    cyc(1); pop_check(64'(irq_req)); pop_check(64'(irq_id)); pop_check(64'(irq_vec));
    irq_in = '0;
    push("t1_ack_pend", 0); push("t1_ack_irw", 3'b001); push("t1_ack_ie", 0); push("t1_ack_req", 0);
    irq_ack = 1; cyc(1); irq_ack = 0;
    pop_check(64'(pending)); pop_check(64'(irw)); pop_check(64'(ie)); pop_check(64'(irq_req));

    // 2: nesting line 2 over line 0
    push("t2_ie", 1);
    ie_set = 1; cyc(1); ie_set = 0;
    pop_check(64'(ie));
    push("t2_req", 1); push("t2_id", 2); push("t2_vec", 32'h120);
    irq_in = 3'b100; cyc(4); irq_in = '0;
    pop_check(64'(irq_req)); pop_check(64'(irq_id)); pop_check(64'(irq_vec));
    push("t2_ack_irw", 3'b101); push("t2_ack_ie", 0);
    irq_ack = 1; cyc(1); irq_ack = 0;
    pop_check(64'(irw)); pop_check(64'(ie));
    push("t2_eret1_irw", 3'b001); push("t2_eret1_ie", 1);
    eret = 1; cyc(1); eret = 0;
    pop_check(64'(irw)); pop_check(64'(ie));
    push("t2_eret2_irw", 0);
    eret = 1; cyc(1); eret = 0;
    pop_check(64'(irw));

    // 3: lower line blocked by in-service line 1
    push("t3_req1", 1); push("t3_id1", 1);
    irq_in = 3'b010; cyc(4); irq_in = '0;
    pop_check(64'(irq_req)); pop_check(64'(irq_id));
    push("t3_ack_irw", 3'b010);
    irq_ack = 1; cyc(1); irq_ack = 0;
    pop_check(64'(irw));
    push("t3_ie", 1);
    ie_set = 1; cyc(1); ie_set = 0;
    pop_check(64'(ie));
    push("t3_pend0", 3'b001); push("t3_blocked_a", 0); push("t3_blocked_b", 0);
    irq_in = 3'b001;
    cyc(3); pop_check(64'(pending));
    cyc(1); pop_check(64'(irq_req));
    cyc(1); pop_check(64'(irq_req));
    irq_in = '0;
    push("t3_eret_irw", 0); push("t3_eret_req", 0); push("t3_late_req", 1); push("t3_late_id", 0);
    eret = 1; cyc(1); eret = 0;
    pop_check(64'(irw)); pop_check(64'(irq_req));
    cyc(1); pop_check(64'(irq_req)); pop_check(64'(irq_id));

    // 4: irq_id held in REQ while line 2 becomes pending
    push("t4_pend", 3'b101); push("t4_id_a", 0); push("t4_req", 1); push("t4_id_b", 0);
    irq_in = 3'b100;
    cyc(3); pop_check(64'(pending)); pop_check(64'(irq_id)); pop_check(64'(irq_req));
    cyc(1); pop_check(64'(irq_id));
    irq_in = '0;
    push("t4_ack_irw", 3'b001); push("t4_ack_pend", 3'b100); push("t4_ack_ie", 0); push("t4_ack_req", 0);
    irq_ack = 1; cyc(1); irq_ack = 0;
    pop_check(64'(irw)); pop_check(64'(pending)); pop_check(64'(ie)); pop_check(64'(irq_req));
    push("t4_noie_req", 0);
    cyc(1); pop_check(64'(irq_req));
    push("t4_ie", 1); push("t4_req2", 1); push("t4_id2", 2); push("t4_vec2", 32'h120);
    ie_set = 1; cyc(1); ie_set = 0;
    pop_check(64'(ie));
    cyc(1); pop_check(64'(irq_req)); pop_check(64'(irq_id)); pop_check(64'(irq_vec));

    // 5a: ack + eret in one cycle
    push("t5_ackeret_irw", 3'b101); push("t5_ackeret_ie", 0); push("t5_ackeret_req", 0);
    push("t5_hold_irw", 3'b001); push("t5_hold_ie", 1);
    irq_ack = 1; eret = 1; cyc(1); irq_ack = 0; eret = 0;
    pop_check(64'(irw)); pop_check(64'(ie)); pop_check(64'(irq_req));
    cyc(1); pop_check(64'(irw)); pop_check(64'(ie));
    push("t5_eret_irw", 0);
    eret = 1; cyc(1); eret = 0;
    pop_check(64'(irw));

    // 5b: ie_set + ie_clr
    push("t5_setclr_ie", 0);
    ie_set = 1; ie_clr = 1; cyc(1); ie_set = 0; ie_clr = 0;
    pop_check(64'(ie));

    // 5c: ie_clr withdraws the request, pending kept
    push("t5c_ie", 1); push("t5c_req", 1); push("t5c_id", 1);
    ie_set = 1; cyc(1); ie_set = 0;
    pop_check(64'(ie));
    irq_in = 3'b010; cyc(4); irq_in = '0;
    pop_check(64'(irq_req)); pop_check(64'(irq_id));
    push("t5c_wd_req", 0); push("t5c_wd_pend", 3'b010); push("t5c_wd_ie", 0); push("t5c_wd_req2", 0);
    ie_clr = 1; cyc(1); ie_clr = 0;
    pop_check(64'(irq_req)); pop_check(64'(pending)); pop_check(64'(ie));
    cyc(1); pop_check(64'(irq_req));
    push("t5c_rereq", 1); push("t5c_reid", 1);
    ie_set = 1; cyc(1); ie_set = 0;
    cyc(1); pop_check(64'(irq_req)); pop_check(64'(irq_id));
    push("t5c_ack_irw", 3'b010); push("t5c_ack_pend", 0);
    irq_ack = 1; cyc(1); irq_ack = 0;
    pop_check(64'(irw)); pop_check(64'(pending));

    // 6: build irw=011, reset while requesting line 2
    push("t6_eret_irw", 0);
    eret = 1; cyc(1); eret = 0;
    pop_check(64'(irw));
    irq_in = 3'b001; cyc(4); irq_in = '0;
    irq_ack = 1; cyc(1); irq_ack = 0;
    ie_set = 1; cyc(1); ie_set = 0;
    irq_in = 3'b010; cyc(4); irq_in = '0;
    push("t6_irw", 3'b011);
    irq_ack = 1; cyc(1); irq_ack = 0;
    pop_check(64'(irw));
    push("t6_req", 1); push("t6_id", 2);
    ie_set = 1; cyc(1); ie_set = 0;
    irq_in = 3'b100; cyc(4);
    pop_check(64'(irq_req)); pop_check(64'(irq_id));
    push("t6_rst_pend", 0); push("t6_rst_irw", 0); push("t6_rst_ie", 0);
    push("t6_rst_req", 0); push("t6_rst_id", 0); push("t6_rst_vec", 32'h100);
    rst = 0; cyc(1);
    pop_check(64'(pending)); pop_check(64'(irw)); pop_check(64'(ie));
    pop_check(64'(irq_req)); pop_check(64'(irq_id)); pop_check(64'(irq_vec));
    rst = 1;
    push("t6_held_pend", 0); push("t6_toggle_pend", 3'b100);
    cyc(8); pop_check(64'(pending));
    irq_in = '0; cyc(3);
    irq_in = 3'b100; cyc(3);
    pop_check(64'(pending));
    irq_in = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
